// File: rtl/sop_sweeper_if.sv
// Stimulus/response bundle between the sweeper and the 4-input SOP stage it exercises.
// Includes the sweep control and the result signals.
interface sop_sweeper_if;
    localparam int unsigned TT_W  = 16;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned IDX_W = 4;

    logic               start;
    logic               f_s;
    logic               a;
    logic               b;
    logic               c;
    logic               d;
    logic               busy;
    logic               done;
    logic [TT_W-1:0]    truth_table;
    logic [CNT_W-1:0]   ones_count;
    logic               pass;
    logic               fail_valid;
    logic [IDX_W-1:0]   first_fail;

    modport master (
        input  start, f_s,
        output a, b, c, d, busy, done, truth_table, ones_count, pass, fail_valid, first_fail
    );

    modport slave (
        output start, f_s,
        input  a, b, c, d, busy, done, truth_table, ones_count, pass, fail_valid, first_fail
    );
endinterface

// File: rtl/sop_sweeper.sv
// Exhaustive 16-vector sweeper for a 4-input SOP stage: drives {a,b,c,d}, captures f_s,
// and reports the captured truth table, its ones count and the first mismatch against EXPECTED.
module sop_sweeper #(
    parameter int unsigned SETTLE   = 1,
    parameter logic [15:0] EXPECTED = 16'h55B5
) (
    input  logic          clk,
    input  logic          rst_n,
    sop_sweeper_if.master bus
);
    localparam int unsigned IDX_W = 4;
    localparam int unsigned SET_W = 3;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned TT_W  = 16;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [TT_W-1:0]    tt_q, tt_d;
    logic [CNT_W-1:0]   ones_q, ones_d;
    logic               pass_q, pass_d;
    logic               fv_q, fv_d;
    logic [IDX_W-1:0]   ff_q, ff_d;

    // State and result registers; reset wipes any partial sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            settle_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tt_q     <= '0;
            ones_q   <= '0;
            pass_q   <= 1'b0;
            fv_q     <= 1'b0;
            ff_q     <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tt_q     <= tt_d;
            ones_q   <= ones_d;
            pass_q   <= pass_d;
            fv_q     <= fv_d;
            ff_q     <= ff_d;
        end
    end

    // Next-state logic; busy/done/vector are computed one edge ahead so they come out registered.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        tt_d     = tt_q;
        ones_d   = ones_q;
        pass_d   = pass_q;
        fv_d     = fv_q;
        ff_d     = ff_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = SWEEP;
                    idx_d    = '0;
                    settle_d = '0;
                    busy_d   = 1'b1;
                    tt_d     = '0;
                    ones_d   = '0;
                    pass_d   = 1'b0;
                    fv_d     = 1'b0;
                    ff_d     = '0;
                end
            end
            SWEEP: begin
                busy_d = 1'b1;
                if (settle_q == SET_W'(SETTLE)) begin
                    tt_d[idx_q] = bus.f_s;
                    ones_d      = ones_q + CNT_W'(bus.f_s);
                    if ((bus.f_s != EXPECTED[idx_q]) && !fv_q) begin
                        fv_d = 1'b1;
                        ff_d = idx_q;
                    end
                    settle_d = '0;
                    if (idx_q == IDX_W'(15)) begin
                        // Pass must include the mismatch seen on this final sample.
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        idx_d   = '0;
                        pass_d  = !fv_d;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign {bus.a, bus.b, bus.c, bus.d} = idx_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.truth_table = tt_q;
    assign bus.ones_count  = ones_q;
    assign bus.pass        = pass_q;
    assign bus.fail_valid  = fv_q;
    assign bus.first_fail  = ff_q;
endmodule

// File: tb/tb_sop_sweeper.sv
// Randomized self-checking bench: two sweepers (SETTLE=1 and SETTLE=0) driven by a table-based
// model of the SOP stage; results checked against a minterm/popcount reference.
module tb_sop_sweeper;
    localparam logic [15:0] EXP = 16'h55B5;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic [3:0]  vec;
        logic [15:0] tt;
        logic [4:0]  ones;
        logic        pass;
        logic        fv;
        logic [3:0]  ff;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] tbls [2];
    logic        start_v [2];
    logic [15:0] gold;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    sop_sweeper_if if0();
    sop_sweeper_if if1();

    assign if0.start = start_v[0];
    assign if1.start = start_v[1];
    assign if0.f_s   = tbls[0][{if0.a, if0.b, if0.c, if0.d}];
    assign if1.f_s   = tbls[1][{if1.a, if1.b, if1.c, if1.d}];

    sop_sweeper #(.SETTLE(1), .EXPECTED(EXP)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.master));
    sop_sweeper #(.SETTLE(0), .EXPECTED(EXP)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.master));

    function automatic obs_t get_obs(input int s);
        if (s == 0)
            return {if0.busy, if0.done, {if0.a, if0.b, if0.c, if0.d}, if0.truth_table,
                    if0.ones_count, if0.pass, if0.fail_valid, if0.first_fail};
        return {if1.busy, if1.done, {if1.a, if1.b, if1.c, if1.d}, if1.truth_table,
                if1.ones_count, if1.pass, if1.fail_valid, if1.first_fail};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] golden_table();
        int mt [9] = '{0, 2, 4, 5, 7, 8, 10, 12, 14};
        logic [15:0] t = '0;
        foreach (mt[i]) t[mt[i]] = 1'b1;
        return t;
    endfunction

    function automatic int popcount16(input logic [15:0] v);
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic int first_mismatch(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i] != EXP[i]) return i;
        return 0;
    endfunction

    task automatic check_all_zero(input string tag);
        obs_t o;
        for (int s = 0; s < 2; s++) begin
            o = get_obs(s);
            check($sformatf("%s_ctl%0d", tag, s), 32'({o.busy, o.done, o.vec, o.pass, o.fv, o.ff}), 32'd0);
            check($sformatf("%s_tt%0d", tag, s), 32'(o.tt), 32'd0);
            check($sformatf("%s_ones%0d", tag, s), 32'(o.ones), 32'd0);
        end
    endtask

    // One full sweep on instance s with stage table tbl; hold keeps start high throughout.
    task automatic sweep(input int s, input logic [15:0] tbl, input bit hold, input string tag);
        int   per;
        int   c;
        bit   vec_ok;
        obs_t o;
        per     = (s == 0) ? 2 : 1;
        tbls[s] = tbl;
        @(posedge clk); #1;
        start_v[s] = 1'b1;
        @(posedge clk); #1;
        if (!hold) start_v[s] = 1'b0;
        o = get_obs(s);
        check({tag, "_accept"}, 32'({o.busy, o.vec}), 32'({1'b1, 4'd0}));
        c      = 0;
        vec_ok = 1'b1;
        while (1) begin
            @(posedge clk); #1;
            c++;
            o = get_obs(s);
            if (o.done || c > 100) break;
            if (!o.busy || o.vec != 4'(c / per)) vec_ok = 1'b0;
        end
        check({tag, "_vecseq"}, 32'(vec_ok), 32'd1);
        check({tag, "_latency"}, 32'(c), 32'(16 * per));
        check({tag, "_busy_at_done"}, 32'(o.busy), 32'd0);
        check({tag, "_tt"}, 32'(o.tt), 32'(tbl));
        check({tag, "_ones"}, 32'(o.ones), 32'(popcount16(tbl)));
        check({tag, "_pass"}, 32'(o.pass), 32'(tbl == EXP));
        check({tag, "_fv"}, 32'(o.fv), 32'(tbl != EXP));
        check({tag, "_ff"}, 32'(o.ff), 32'(first_mismatch(tbl)));
        @(posedge clk); #1;
        o = get_obs(s);
        check({tag, "_after"}, 32'({o.busy, o.done}), 32'd0);
        check({tag, "_hold_tt"}, 32'(o.tt), 32'(tbl));
        start_v[s] = 1'b0;
    endtask

    initial begin
        logic [15:0] one;
        logic [15:0] t;
        int          s;
        gold       = golden_table();
        one        = 16'h0001;
        tbls[0]    = '0;
        tbls[1]    = '0;
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        rst_n      = 1'b0;
        #12;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        sweep(0, gold, 1'b0, "golden");
        sweep(0, 16'h0000, 1'b0, "tied0");
        sweep(0, gold | 16'h0002, 1'b0, "fault1");
        sweep(0, gold, 1'b1, "hold");
        sweep(1, gold, 1'b0, "settle0");

        // Reset mid-sweep, then a clean restart.
        tbls[0] = gold;
        @(posedge clk); #1;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_all_zero("midrst_rel");
        sweep(0, gold, 1'b0, "post_rst");

        for (int i = 0; i < 8; i++) begin
            s = int'($urandom_range(1));
            if ($urandom_range(1) == 0) t = 16'($urandom);
            else t = gold ^ (one << $urandom_range(15));
            sweep(s, t, 1'($urandom_range(1)), $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sop_sweeper.md
# sop_sweeper

Self-checking exhaustive stimulus generator for the 4-input sum-of-products stage. On a start pulse it drives all 16 input combinations onto `a,b,c,d`, with `a` as MSB, one vector at a time. It samples the stage's `f_s` output for each vector, builds the captured 16-bit truth table, counts ones, and compares against an expected table. It sits directly upstream of the SOP function, feeding its inputs, and also consumes its single output.

## Interface
- `SETTLE`, default 1: extra hold cycles per vector before sampling `f_s`; legal range 0..7.
- `EXPECTED`, default 16'h55B5: golden truth table, bit i = f(i), i = {a,b,c,d}. Minterms 0,2,4,5,7,8,10,12,14.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  sweep request, sampled only in IDLE.
- `f_s`  in  1  output of the SOP stage under test.
- `a`, `b`, `c`, `d`  out  1 each  registered stimulus, {a,b,c,d} = current vector index.
- `busy`  out  1  high while sweeping.
- `done`  out  1  one-cycle pulse when results are valid.
- `truth_table`  out  16  captured f_s per vector; held until next start.
- `ones_count`  out  5  number of 1s captured, 0..16.
- `pass`  out  1  truth_table == EXPECTED; valid from done onward.
- `fail_valid`  out  1  at least one mismatch seen.
- `first_fail`  out  4  index of first mismatching vector; 0 if none.

## Operation
- FSM states: IDLE, SWEEP, DONE. Reset state is IDLE.
- IDLE:
  - `busy`=0; `a,b,c,d`=0.
  - On `start`=1: go to SWEEP with idx=0 and settle_cnt=0.
  - Clear truth_table, ones_count, fail_valid, first_fail, and pass.
- SWEEP:
  - `busy`=1; {a,b,c,d}=idx, registered.
  - settle_cnt counts 0..SETTLE.
  - On the edge where settle_cnt==SETTLE:
    - Write truth_table[idx] <= f_s.
    - ones_count += f_s.
    - If f_s != EXPECTED[idx] and fail_valid==0: fail_valid <= 1 and first_fail <= idx.
    - If idx==15, go to DONE; otherwise idx+1 and settle_cnt <= 0.
- DONE:
  - `done`=1 for exactly one cycle; `busy`=0.
  - `pass` = !fail_valid, registered on the DONE-entry edge.
  - Unconditionally return to IDLE next edge.
- Results (truth_table, ones_count, pass, fail_valid, first_fail) persist through IDLE until the next accepted start.
- `start` is ignored in SWEEP and DONE; no queuing.
- Widths:
  - idx is 4 bits; it never wraps, because terminal detection happens at 15.
  - settle_cnt is 3 bits.
  - ones_count is 5 bits; reaching 16 is legal.
- Reset, asserted at any time including mid-sweep, asynchronously forces:
  - IDLE.
  - All outputs 0: a,b,c,d, busy, done, truth_table=16'h0000, ones_count=0, pass=0, fail_valid=0, first_fail=0.
  - No partial results survive.

## Timing
- `start` sampled high at edge k: busy=1 and vector 0 driven after edge k.
- Each vector is held for SETTLE+1 cycles. `f_s` is sampled at the last edge of that window, so the combinational SOP path has at least SETTLE+1 cycles to settle.
- `done` is high during the cycle after edge k+16·(SETTLE+1): 32 cycles with the default SETTLE=1, 16 cycles with SETTLE=0.
- `busy` falls on the same edge that `done` rises.
- Earliest restart: start sampled at the edge ending DONE is ignored; start is accepted on the next IDLE cycle.
- `a,b,c,d` change only on clock edges and are glitch-free.

## Test plan
- Golden SOP connected, default parameters, start pulse:
  - truth_table=16'h55B5, ones_count=9, pass=1, fail_valid=0, first_fail=0.
  - done pulses exactly 32 cycles after start is sampled.
- `f_s` tied 0: truth_table=16'h0000, ones_count=0, pass=0, fail_valid=1, first_fail=0.
- Golden SOP but `f_s` forced 1 only when {a,b,c,d}=4'b0001 (injected fault): truth_table=16'h55B7, ones_count=10, pass=0, first_fail=1.
- Reset pulsed low at cycle 10 of a sweep:
  - All outputs 0 immediately, asynchronously.
  - A new start afterwards completes with golden results.
- start held high throughout the sweep: no restart mid-sweep; exactly one done pulse; vector sequence is 0..15 monotonic.
- SETTLE=0, golden SOP: each vector lasts 1 cycle; done 16 cycles after start; truth_table=16'h55B5.
